// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, FSM state encoding and VEC_LEN bound for the dot-product MAC path
package mac_pkg;

    localparam int A_W     = 4;
    localparam int ACC_W   = 16;
    localparam int MUL_LAT = 3;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_FEED   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } mac_state_e;

    // Largest vector length whose worst-case sum of (2**A_W-1)**2 products fits acc_w bits.
    function automatic int vec_len_max(input int acc_w);
        longint max_prod;
        longint acc_max;
        max_prod = longint'((2 ** A_W - 1) * (2 ** A_W - 1));
        acc_max  = (longint'(1) << acc_w) - 1;
        return int'(acc_max / max_prod);
    endfunction

endpackage

// File: rtl/mac_4x4.sv
// rtl/mac_4x4.sv - 4x4 unsigned multiplier with MUL_LAT pipeline stages feeding an accumulator
module mac_4x4
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    output logic [ACC_W-1:0] acc
);

    logic [2*A_W-1:0] prod_q [MUL_LAT];
    logic [MUL_LAT-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            acc   <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            prod_q[0] <= (2*A_W)'(a) * (2*A_W)'(b);
            vld_q[0]  <= en;
            for (int i = 1; i < MUL_LAT; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
            if (vld_q[MUL_LAT-1]) begin
                acc <= acc + ACC_W'(prod_q[MUL_LAT-1]);
            end
        end
    end

endmodule

// File: rtl/mac_dot_ctrl.sv
// rtl/mac_dot_ctrl.sv - dot-product sequencer driving mac_4x4; MAC_DOT_ZSKIP_EN enables zero-operand skip
module mac_dot_ctrl
    import mac_pkg::*;
#(
    parameter int VEC_LEN = 4,
    parameter int MUL_LAT = mac_pkg::MUL_LAT,
    parameter int ACC_W   = mac_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [A_W-1:0]   in_b,
    output logic [A_W-1:0]   mac_a,
    output logic [A_W-1:0]   mac_b,
    output logic             mac_en,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    localparam logic [1:0] CLEAR  = ST_CLEAR;
    localparam logic [1:0] FEED   = ST_FEED;
    localparam logic [1:0] DRAIN  = ST_DRAIN;
    localparam logic [1:0] RESULT = ST_RESULT;

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int DRN_W = $clog2(MUL_LAT + 2);
    localparam logic [CNT_W-1:0] LAST_ELEM  = CNT_W'(VEC_LEN - 1);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(MUL_LAT + 1);

    if (VEC_LEN < 1 || VEC_LEN > vec_len_max(ACC_W)) begin : g_bad_vec_len
        $error("mac_dot_ctrl: VEC_LEN out of range for ACC_W");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] elem_cnt;
    logic [DRN_W-1:0] drain_cnt;

    assign in_ready = (state == FEED);
    assign mac_clr  = (state == CLEAR) && !rst;
    assign busy     = !((state == FEED) && (elem_cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            elem_cnt  <= '0;
            drain_cnt <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_en    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            mac_en <= 1'b0;
            case (state)
                CLEAR: state <= FEED;
                FEED: begin
                    if (in_valid) begin
`ifdef MAC_DOT_ZSKIP_EN
                        // A zero operand contributes nothing, so leave the multiplier idle.
                        if (in_a != '0 && in_b != '0) begin
                            mac_a  <= in_a;
                            mac_b  <= in_b;
                            mac_en <= 1'b1;
                        end
`else
                        mac_a  <= in_a;
                        mac_b  <= in_b;
                        mac_en <= 1'b1;
`endif
                        if (elem_cnt == LAST_ELEM) begin
                            elem_cnt  <= '0;
                            drain_cnt <= DRAIN_LOAD;
                            state     <= DRAIN;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                // Covers the last enable cycle, the multiplier stages and the accumulate edge.
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        res_data  <= mac_out;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= CLEAR;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb/tb_mac_dot_ctrl.sv - scoreboard bench for mac_dot_ctrl integrated with mac_4x4
module tb_mac_dot_ctrl;
    import mac_pkg::*;

    localparam int VL = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [A_W-1:0]   in_b;
    logic [A_W-1:0]   mac_a;
    logic [A_W-1:0]   mac_b;
    logic             mac_en;
    logic             mac_clr;
    logic [ACC_W-1:0] mac_out;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             busy;
    logic             mac_rst;

    always #5 clk = ~clk;

    mac_dot_ctrl #(.VEC_LEN(VL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    assign mac_rst = rst | mac_clr;

    mac_4x4 u_mac (
        .clk(clk), .rst(mac_rst), .en(mac_en), .a(mac_a), .b(mac_b), .acc(mac_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int acc_t[$];
    int cyc = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int overlap = 0;
    logic rr_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is handed over.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mac_en) en_cnt++;
            if (mac_clr) clr_cnt++;
            if (mac_en && mac_clr) overlap++;
            if (res_valid && res_ready) begin
                acc_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL res_unexpected: got %0d expected no result", res_data);
                end else begin
                    check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input int a, input int b);
        int t;
        in_valid = 1'b1;
        in_a = 4'(a);
        in_b = 4'(b);
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                check("in_ready_timeout", 32'(t), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int a[VL], input int b[VL], input int gap);
        int sum;
        sum = 0;
        for (int i = 0; i < VL; i++) begin
            send(a[i], b[i]);
            sum += a[i] * b[i];
            if (gap > 0 && i < VL - 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        exp_q.push_back(sum);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic int nz_pairs(input int a[VL], input int b[VL]);
        int n;
        n = 0;
        for (int i = 0; i < VL; i++) begin
`ifdef MAC_DOT_ZSKIP_EN
            if (a[i] != 0 && b[i] != 0) n++;
`else
            n++;
`endif
        end
        return n;
    endfunction

    initial begin
        int basic_a[VL] = '{1, 3, 5, 7};
        int basic_b[VL] = '{2, 4, 6, 8};
        int max_v[VL]   = '{15, 15, 15, 15};
        int two_v[VL]   = '{2, 2, 2, 2};
        int z_a[VL]     = '{0, 3, 5, 7};
        int z_b[VL]     = '{9, 4, 0, 8};
        int ra[VL];
        int rb[VL];
        int e0;
        int c0;
        int t;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_mac_en", 32'(mac_en), 32'd0);
        check("rst_mac_clr", 32'(mac_clr), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_mac_a", 32'(mac_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("clear_mac_clr", 32'(mac_clr), 32'd1);
        check("clear_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("feed_in_ready", 32'(in_ready), 32'd1);
        check("feed_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Two basic vectors back-to-back: period and clear pulses.
        acc_t.delete();
        e0 = en_cnt;
        c0 = clr_cnt;
        send_vec(basic_a, basic_b, 0);
        send_vec(basic_a, basic_b, 0);
        wait_drain();
        repeat (3) @(negedge clk);
        check("period", 32'(acc_t.size() >= 2 ? acc_t[1] - acc_t[0] : 0), 32'd11);
        check("clr_pulses", 32'(clr_cnt - c0), 32'd2);
        check("basic_en_cnt", 32'(en_cnt - e0), 32'd8);
        @(posedge clk);
        #1;

        send_vec(max_v, max_v, 0);
        send_vec(max_v, max_v, 0);
        wait_drain();

        e0 = en_cnt;
        send_vec(basic_a, basic_b, 2);
        wait_drain();
        repeat (3) @(negedge clk);
        check("bubble_en_cnt", 32'(en_cnt - e0), 32'd4);
        @(posedge clk);
        #1;

        // Result backpressure.
        res_ready = 1'b0;
        send_vec(basic_a, basic_b, 0);
        t = 0;
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd1);
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_data", 32'(res_data), 32'd100);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send_vec(two_v, two_v, 0);
        wait_drain();

        // Reset in the middle of FEED discards the partial vector.
        send(3, 3);
        send(9, 9);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_vec(basic_a, basic_b, 0);
        wait_drain();

        e0 = en_cnt;
        send_vec(z_a, z_b, 0);
        wait_drain();
        repeat (3) @(negedge clk);
        check("zero_en_cnt", 32'(en_cnt - e0), 32'(nz_pairs(z_a, z_b)));
        @(posedge clk);
        #1;

        rr_rand = 1'b1;
        for (int v = 0; v < 25; v++) begin
            for (int i = 0; i < VL; i++) begin
                ra[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
                rb[i] = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 15));
            end
            send_vec(ra, rb, int'($urandom_range(0, 2)));
        end
        wait_drain();
        rr_rand = 1'b0;
        res_ready = 1'b1;

        check("en_during_clr", 32'(overlap), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
